regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the in-order pipeline writeback (port A) and a long-latency unit such as MUL/DIV (port B).
- Port B results are buffered in a small FIFO.
- A starvation counter guarantees B progress while A is continuously busy.
- Outputs are registered and drive the register file's write port (wen/waddr/wdata).
- Exports a pending-write busy vector so the decode stage can detect hazards.

---
 rtl/regfile_wb_arbiter_pkg.sv | 11 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency writeback results; exposes per-entry
// valid/address so the owner can build a pending-write vector.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic                                 pop,
  input  wb_req_t                              din,
  output wb_req_t                              head,
  output logic [PTR_W:0]                       count,
  output logic                                 full,
  output logic                                 empty,
  output logic [DEPTH-1:0]                     ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_addr
);
  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]  = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
      ent_addr[i] = mem[i].waddr;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (A)
// and a buffered long-latency unit (B), with starvation protection for B.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN     = regfile_wb_arbiter_pkg::XLEN,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_waddr,
  input  logic [XLEN-1:0]       a_wdata,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_waddr,
  input  logic [XLEN-1:0]       b_wdata,
  output logic                  b_ready,
  output logic                  reg_wen,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [XLEN-1:0]       reg_wdata_o,
  output logic [NREGS-1:0]      busy_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int WCW   = $clog2(MAX_WAIT + 1);

  wb_req_t                          b_req, head, sel;
  logic [PTR_W:0]                   count;
  logic                             full, empty, push, pop;
  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic [WCW-1:0]                   wait_cnt;
  logic                             head_due, grant_a, grant_b;
  logic [NREGS-1:0]                 busy;

  assign b_req = '{waddr: b_waddr, wdata: b_wdata};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (b_req),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  // Head wins when A is idle or has bypassed it MAX_WAIT times.
  assign head_due = !empty && (wait_cnt == WCW'(MAX_WAIT) || !a_valid);
  assign grant_b  = rst && head_due;
  assign grant_a  = rst && a_valid && !grant_b;
  assign a_ready  = rst && !grant_b;
  assign b_ready  = rst && !full;
  assign push     = b_valid && b_ready;
  assign pop      = grant_b;
  assign sel      = grant_b ? head : '{waddr: a_waddr, wdata: a_wdata};

  always_ff @(posedge clk) begin
    if (!rst)                         wait_cnt <= '0;
    else if (pop || empty)            wait_cnt <= '0;
    else if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  // x0 writes still take the grant (and are consumed) but never raise wen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_wen     <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else if (grant_a || grant_b) begin
      reg_wen     <= (sel.waddr != '0);
      reg_waddr_o <= sel.waddr;
      reg_wdata_o <= sel.wdata;
    end else begin
      reg_wen     <= 1'b0;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) busy[ent_addr[i]] = 1'b1;
    if (reg_wen) busy[reg_waddr_o] = 1'b1;
    busy[0] = 1'b0;
  end

  assign busy_o = rst ? busy : '0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single-port writes, starvation,
// backpressure ordering, x0 handling and mid-operation reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready, reg_wen;
  logic [4:0]  a_waddr, b_waddr, reg_waddr_o;
  logic [63:0] a_wdata, b_wdata, reg_wdata_o;
  logic [31:0] busy_o;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
    .reg_wen(reg_wen), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .busy_o(busy_o)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_waddr = 5'd1; a_wdata = 64'h11; b_waddr = 5'd2; b_wdata = 64'h22;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL rst_wen got %b exp 0", reg_wen); end
      tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL rst_a_ready got %b exp 0", a_ready); end
      tests++; if (b_ready !== 1'b0) begin fails++; $display("FAIL rst_b_ready got %b exp 0", b_ready); end
      tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL rst_busy got %h exp 0", busy_o); end
    end
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
    cyc();
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL rel_b_ready got %b exp 1", b_ready); end
    tests++; if (dut.count !== 3'd0) begin fails++; $display("FAIL rel_count got %0d exp 0", dut.count); end
    tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL rel_wen got %b exp 0", reg_wen); end
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 64'h1234;
    #1;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL a_ready got %b exp 1", a_ready); end
    tests++; if (busy_o[5] !== 1'b0) begin fails++; $display("FAIL a_busy_t got %b exp 0", busy_o[5]); end
    cyc(); a_valid = 1'b0;
    tests++; if ({reg_wen, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd5, 64'h1234}) begin
      fails++; $display("FAIL a_write got wen=%b a=%0d d=%h exp wen=1 a=5 d=1234", reg_wen, reg_waddr_o, reg_wdata_o); end
    tests++; if (busy_o !== 32'h20) begin fails++; $display("FAIL a_busy_t1 got %h exp 00000020", busy_o); end
    cyc();
    tests++; if (reg_wen !== 1'b0 || busy_o !== 32'h0) begin
      fails++; $display("FAIL a_idle got wen=%b busy=%h exp wen=0 busy=0", reg_wen, busy_o); end
  endtask

  task automatic test_b_only();
    b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 64'hDEAD;
    #1;
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL b_ready got %b exp 1", b_ready); end
    cyc(); b_valid = 1'b0;
    tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL b_grant got a_ready=%b exp 0", a_ready); end
    tests++; if (busy_o !== 32'h80) begin fails++; $display("FAIL b_busy_t1 got %h exp 00000080", busy_o); end
    cyc();
    tests++; if ({reg_wen, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd7, 64'hDEAD}) begin
      fails++; $display("FAIL b_write got wen=%b a=%0d d=%h exp wen=1 a=7 d=dead", reg_wen, reg_waddr_o, reg_wdata_o); end
    tests++; if (busy_o !== 32'h80) begin fails++; $display("FAIL b_busy_t2 got %h exp 00000080", busy_o); end
    cyc();
    tests++; if (busy_o !== 32'h0 || reg_wen !== 1'b0) begin
      fails++; $display("FAIL b_done got busy=%h wen=%b exp 0 0", busy_o, reg_wen); end
  endtask

  task automatic test_starvation();
    a_valid = 1'b1; a_waddr = 5'd3; a_wdata = 64'hA3;
    b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 64'hB9;
    #1;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL st_t0 a_ready got %b exp 1", a_ready); end
    cyc(); b_valid = 1'b0;
    tests++; if (reg_wen !== 1'b1 || reg_waddr_o !== 5'd3) begin
      fails++; $display("FAIL st_a_wr got wen=%b a=%0d exp 1 3", reg_wen, reg_waddr_o); end
    for (int k = 1; k <= 3; k++) begin
      tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL st_bypass%0d a_ready got %b exp 1", k, a_ready); end
      cyc();
    end
    tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL st_force a_ready got %b exp 0", a_ready); end
    cyc();
    tests++; if ({reg_wen, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd9, 64'hB9}) begin
      fails++; $display("FAIL st_b_wr got wen=%b a=%0d d=%h exp 1 9 b9", reg_wen, reg_waddr_o, reg_wdata_o); end
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL st_resume a_ready got %b exp 1", a_ready); end
    cyc();
    tests++; if (reg_wen !== 1'b1 || reg_waddr_o !== 5'd3) begin
      fails++; $display("FAIL st_a_again got wen=%b a=%0d exp 1 3", reg_wen, reg_waddr_o); end
  endtask

  task automatic test_full();
    int idx = 0, got = 0, bad = 0;
    bit chk4 = 0, acc;
    a_valid = 1'b1; a_waddr = 5'd3;
    for (int c = 0; c < 80 && got < 5; c++) begin
      if (reg_wen && reg_waddr_o >= 5'd10) begin
        if (reg_waddr_o !== 5'(10 + got) || reg_wdata_o !== 64'(32'h100 + 10 + got)) begin
          bad++; $display("FAIL full_order got a=%0d d=%h exp a=%0d", reg_waddr_o, reg_wdata_o, 10 + got);
        end
        got++;
      end
      if (idx < 5) begin b_valid = 1'b1; b_waddr = 5'(10 + idx); b_wdata = 64'(32'h100 + 10 + idx); end
      else b_valid = 1'b0;
      #1;
      if (idx == 4 && !chk4) begin
        chk4 = 1; tests++;
        if (b_ready !== 1'b0) begin fails++; $display("FAIL full_b_ready got %b exp 0", b_ready); end
      end
      acc = b_valid && b_ready;
      cyc();
      if (acc) idx++;
    end
    b_valid = 1'b0; a_valid = 1'b0;
    tests++; if (bad != 0) fails++;
    tests++; if (got != 5) begin fails++; $display("FAIL full_drain got %0d writes exp 5", got); end
    cyc();
  endtask

  task automatic test_x0_and_reset();
    int bad = 0;
    a_valid = 1'b1; a_waddr = 5'd0; a_wdata = 64'hFF;
    #1;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL x0_a_ready got %b exp 1", a_ready); end
    cyc();
    tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL x0_wen got %b exp 0", reg_wen); end
    a_waddr = 5'd4; a_wdata = 64'h44;
    for (int k = 0; k < 3; k++) begin
      b_valid = 1'b1; b_waddr = 5'(20 + k); b_wdata = 64'(k);
      cyc();
    end
    b_valid = 1'b0;
    tests++; if (busy_o !== 32'h0070_0010) begin fails++; $display("FAIL pre_rst_busy got %h exp 00700010", busy_o); end
    rst = 1'b0; a_valid = 1'b0;
    #1;
    tests++; if (busy_o !== 32'h0 || a_ready !== 1'b0) begin
      fails++; $display("FAIL in_rst got busy=%h a_ready=%b exp 0 0", busy_o, a_ready); end
    cyc(); rst = 1'b1;
    #1;
    tests++; if (dut.count !== 3'd0) begin fails++; $display("FAIL mid_rst_count got %0d exp 0", dut.count); end
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL mid_rst_busy got %h exp 0", busy_o); end
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (reg_wen !== 1'b0) begin bad++; $display("FAIL post_rst_wen cycle %0d got %b exp 0", k, reg_wen); end
    end
    tests++; if (bad != 0) fails++;
  endtask

  initial begin
    a_valid = 1'b0; b_valid = 1'b0; a_waddr = '0; b_waddr = '0;
    a_wdata = '0; b_wdata = '0; rst = 1'b0;
    test_reset();
    test_a_only();
    test_b_only();
    test_starvation();
    test_full();
    test_x0_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
